// File: rtl/recovery_csr_restorer_if.sv
// rtl/recovery_csr_restorer_if.sv - snapshot type and CSR write-port interface for the recovery CSR restorer
//
// recovery_csr_pkg::csrs_intf_t : machine-mode CSR snapshot held by the recovery CSR storage.
// recovery_csr_restorer_if      : 12-bit-address CSR write port with req/gnt handshake.
//   req   - write request (master -> slave)
//   addr  - CSR address, held until grant (master -> slave)
//   wdata - CSR write data, held until grant (master -> slave)
//   gnt   - grant; a transfer completes when req & gnt (slave -> master)
//   rdata - combinational readback of addr (slave -> master)

package recovery_csr_pkg;

  typedef struct packed {
    logic [31:0] mie;
    logic [31:0] mscratch;
    logic [31:0] mip;
    logic [31:0] mepc;
    logic [23:0] mtvec;
    logic [5:0]  mcause;
    logic [6:0]  mstatus;
  } csrs_intf_t;

endpackage

interface recovery_csr_restorer_if;
  logic        req;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    output wdata,
    input  gnt,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    input  wdata,
    output gnt,
    output rdata
  );
endinterface

// File: rtl/recovery_csr_restorer.sv
// rtl/recovery_csr_restorer.sv - replays the recovery CSR snapshot into the core after a rollback
//
// On start_i the snapshot is read once from the recovery CSR storage (one-cycle
// read_enable_o) and then written into the core one CSR per req/gnt transfer,
// mstatus last so interrupts cannot re-enable part way through.
//
// Optional feature: macro RECOVERY_CSR_VERIFY_EN adds a CHECK cycle after each
// grant that compares the readback against the written value (masked to the
// CSR's field width) and sets the sticky error_o on mismatch.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset
//   start_i        - restore request pulse, sampled only in IDLE
//   read_enable_o  - read enable to the recovery CSR storage (LOAD only)
//   recovery_csr_i - snapshot from the storage, valid while read_enable_o=1
//   csr            - CSR write port (master side)
//   busy_o         - high in every state except IDLE
//   done_o         - one-cycle pulse when the restore completes
//   error_o        - sticky readback mismatch flag (0 without the macro)

module recovery_csr_restorer
  import recovery_csr_pkg::*;
#(
  parameter int unsigned NumCsrs = 7
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  output logic                           read_enable_o,
  input  csrs_intf_t                     recovery_csr_i,
  recovery_csr_restorer_if.master        csr,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam logic [2:0] LastIdx = 3'(NumCsrs - 1);

`ifdef RECOVERY_CSR_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd4
  } state_t;
`endif

  state_t     state;
  csrs_intf_t snap;
  logic [2:0] idx;

  // Restore order: mstatus goes last.
  function automatic logic [11:0] addr_of(input logic [2:0] i);
    case (i)
      3'd0:    addr_of = 12'h305;  // mtvec
      3'd1:    addr_of = 12'h340;  // mscratch
      3'd2:    addr_of = 12'h341;  // mepc
      3'd3:    addr_of = 12'h342;  // mcause
      3'd4:    addr_of = 12'h344;  // mip
      3'd5:    addr_of = 12'h304;  // mie
      default: addr_of = 12'h300;  // mstatus
    endcase
  endfunction

  // Narrow snapshot fields are zero-extended to the 32-bit write bus.
  function automatic logic [31:0] wdata_of(input csrs_intf_t s, input logic [2:0] i);
    case (i)
      3'd0:    wdata_of = {8'd0, s.mtvec};
      3'd1:    wdata_of = s.mscratch;
      3'd2:    wdata_of = s.mepc;
      3'd3:    wdata_of = {26'd0, s.mcause};
      3'd4:    wdata_of = s.mip;
      3'd5:    wdata_of = s.mie;
      default: wdata_of = {25'd0, s.mstatus};
    endcase
  endfunction

`ifdef RECOVERY_CSR_VERIFY_EN
  // Only the implemented field bits take part in the readback compare.
  function automatic logic [31:0] mask_of(input logic [2:0] i);
    case (i)
      3'd0:    mask_of = 32'h00FF_FFFF;
      3'd3:    mask_of = 32'h0000_003F;
      3'd6:    mask_of = 32'h0000_007F;
      default: mask_of = 32'hFFFF_FFFF;
    endcase
  endfunction

  logic error_q;
  logic mismatch;

  // Address and write data are still held in CHECK, so the live readback
  // is compared against the registered write data.
  assign mismatch = (state == CHECK) && ((csr.rdata & mask_of(idx)) != csr.wdata);

  // The flag shows in the CHECK cycle itself and is then held by error_q.
  assign error_o = error_q | mismatch;
`else
  logic unused_rdata;

  assign unused_rdata = ^csr.rdata;
  assign error_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      snap          <= '0;
      idx           <= '0;
      read_enable_o <= 1'b0;
      csr.req       <= 1'b0;
      csr.addr      <= '0;
      csr.wdata     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
`ifdef RECOVERY_CSR_VERIFY_EN
      error_q       <= 1'b0;
`endif
    end else begin
      read_enable_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= LOAD;
            read_enable_o <= 1'b1;
            busy_o        <= 1'b1;
`ifdef RECOVERY_CSR_VERIFY_EN
            // Cleared on entry so error_o is already low during LOAD.
            error_q       <= 1'b0;
`endif
          end
        end

        LOAD: begin
          // The storage output is only valid now, so the first transfer is
          // decoded straight from it rather than from the snapshot register.
          snap      <= recovery_csr_i;
          idx       <= 3'd0;
          state     <= WRITE;
          csr.req   <= 1'b1;
          csr.addr  <= addr_of(3'd0);
          csr.wdata <= wdata_of(recovery_csr_i, 3'd0);
        end

        WRITE: begin
          if (csr.gnt) begin
`ifdef RECOVERY_CSR_VERIFY_EN
            state   <= CHECK;
            csr.req <= 1'b0;
`else
            if (idx == LastIdx) begin
              state     <= DONE;
              csr.req   <= 1'b0;
              csr.addr  <= '0;
              csr.wdata <= '0;
              done_o    <= 1'b1;
            end else begin
              idx       <= idx + 3'd1;
              csr.addr  <= addr_of(idx + 3'd1);
              csr.wdata <= wdata_of(snap, idx + 3'd1);
            end
`endif
          end
        end

`ifdef RECOVERY_CSR_VERIFY_EN
        CHECK: begin
          if (mismatch) begin
            error_q <= 1'b1;
          end
          if (idx == LastIdx) begin
            state     <= DONE;
            csr.addr  <= '0;
            csr.wdata <= '0;
            done_o    <= 1'b1;
          end else begin
            state     <= WRITE;
            idx       <= idx + 3'd1;
            csr.req   <= 1'b1;
            csr.addr  <= addr_of(idx + 3'd1);
            csr.wdata <= wdata_of(snap, idx + 3'd1);
          end
        end
`endif

        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          read_enable_o <= 1'b0;
          csr.req       <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule
